// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store unit. Accepts one memory op from
// decode, checks width/alignment, runs one req/gnt/rvalid bus transaction,
// and returns extended load data, a completion pulse, or an exception pulse.
module core_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  is_store_in,
  input  logic [2:0]            funct3_in,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           wdata_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [31:0]           mem_addr_out,
  output logic [3:0]            mem_be_out,
  output logic [31:0]           mem_wdata_out,
  input  logic                  mem_gnt_in,
  input  logic                  mem_rvalid_in,
  input  logic [31:0]           mem_rdata_in,
  output logic                  wb_valid_out,
  output logic [REG_ADDR_W-1:0] wb_rd_out,
  output logic [31:0]           wb_data_out,
  output logic                  done_out,
  output logic                  exc_valid_out,
  output logic [1:0]            exc_cause_out,
  output logic [31:0]           exc_addr_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    op_store;
  logic [2:0]              op_f3;
  logic [31:0]             op_addr;
  logic [REG_ADDR_W-1:0]   op_rd;

  logic                    width_ok, misaligned;
  logic [3:0]              be_calc;
  logic [31:0]             wdata_calc;
  logic [31:0]             lane, load_ext;
  logic                    timeout_hit;

  logic                    do_latch, fire_exc, fire_wb, fire_done;
  logic [1:0]              cause_nxt;
  logic [31:0]             exc_addr_nxt;

  // Decode width legality, alignment, byte enables and lane-replicated store data
  always_comb begin
    width_ok   = 1'b0;
    misaligned = 1'b0;
    be_calc    = '0;
    wdata_calc = wdata_in;
    case (funct3_in)
      3'b000: begin
        width_ok   = 1'b1;
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      3'b001: begin
        width_ok   = 1'b1;
        misaligned = addr_in[0];
        be_calc    = 4'b0011 << addr_in[1:0];
        wdata_calc = {2{wdata_in[15:0]}};
      end
      3'b010: begin
        width_ok   = 1'b1;
        misaligned = |addr_in[1:0];
        be_calc    = 4'b1111;
      end
      3'b100: begin
        width_ok = !is_store_in;
        be_calc  = 4'b0001 << addr_in[1:0];
      end
      3'b101: begin
        width_ok   = !is_store_in;
        misaligned = addr_in[0];
        be_calc    = 4'b0011 << addr_in[1:0];
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down and sign/zero-extend per the latched width
  always_comb begin
    lane = mem_rdata_in >> {op_addr[1:0], 3'b000};
    case (op_f3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = mem_rdata_in;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LAST);

  // Next-state and event decode; bus handshakes take priority over the timeout
  always_comb begin
    state_nxt    = state;
    do_latch     = 1'b0;
    fire_exc     = 1'b0;
    fire_wb      = 1'b0;
    fire_done    = 1'b0;
    cause_nxt    = 2'b00;
    exc_addr_nxt = op_addr;
    case (state)
      S_IDLE: begin
        if (req_valid_in && req_ready_out) begin
          if (!width_ok) begin
            fire_exc     = 1'b1;
            cause_nxt    = 2'b11;
            exc_addr_nxt = addr_in;
          end else if (misaligned) begin
            fire_exc     = 1'b1;
            cause_nxt    = is_store_in ? 2'b10 : 2'b01;
            exc_addr_nxt = addr_in;
          end else begin
            do_latch  = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_in) begin
          state_nxt = S_WAIT;
        end else if (timeout_hit) begin
          fire_exc  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_in) begin
          fire_done = 1'b1;
          fire_wb   = !op_store;
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          fire_exc  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter: cleared on entry to REQ, saturates at the last allowed cycle
  // so a late grant still leaves the WAIT phase bounded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (do_latch) begin
      tmo_cnt <= '0;
    end else if (state != S_IDLE && tmo_cnt != CNT_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Latch the accepted op for response handling and timeout reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_rd    <= '0;
    end else if (do_latch) begin
      op_store <= is_store_in;
      op_f3    <= funct3_in;
      op_addr  <= addr_in;
      op_rd    <= rd_in;
    end
  end

  // Registered outputs: handshake flags follow next state, data fields load on events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_out <= 1'b1;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_be_out    <= '0;
      mem_wdata_out <= '0;
      wb_valid_out  <= 1'b0;
      wb_rd_out     <= '0;
      wb_data_out   <= '0;
      done_out      <= 1'b0;
      exc_valid_out <= 1'b0;
      exc_cause_out <= '0;
      exc_addr_out  <= '0;
    end else begin
      req_ready_out <= (state_nxt == S_IDLE);
      mem_req_out   <= (state_nxt == S_REQ);
      wb_valid_out  <= fire_wb;
      done_out      <= fire_done;
      exc_valid_out <= fire_exc;
      if (do_latch) begin
        mem_we_out    <= is_store_in;
        mem_addr_out  <= {addr_in[31:2], 2'b00};
        mem_be_out    <= be_calc;
        mem_wdata_out <= wdata_calc;
      end
      if (fire_wb) begin
        wb_rd_out   <= op_rd;
        wb_data_out <= load_ext;
      end
      if (fire_exc) begin
        exc_cause_out <= cause_nxt;
        exc_addr_out  <= exc_addr_nxt;
      end
    end
  end

endmodule
